sr_latch_driver: RTL and testbench

- Synchronous front-end that drives the S/R inputs of the NAND-style sr_latch. S and R are active-low; S=R=1 means hold.
- Accepts set/clear commands over a valid/ready handshake and turns each into a timed single-rail pulse.
- Guarantees the latch never sees S=R=0, and never sees a 00->11 release, so the latch cannot go indeterminate.
- Forces the latch to a known state after reset and keeps a shadow copy of the expected Q.

---
 rtl/sr_latch_driver_if.sv | 19 +
 rtl/sr_latch_driver.sv | 153 +++++++++++++++
 tb/tb_sr_latch_driver.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sr_latch_driver_if.sv
// Command handshake between a requester and sr_latch_driver.
// cmd_op: 01 = set, 10 = clear, anything else is illegal.
interface sr_latch_driver_if;
  logic       cmd_valid;
  logic [1:0] cmd_op;
  logic       cmd_ready;

  modport master (
    output cmd_valid,
    output cmd_op,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_op,
    output cmd_ready
  );
endinterface

// File: rtl/sr_latch_driver.sv
// Drives active-low S/R of a NAND latch with timed single-rail pulses.
// S=R=0 is never produced and only one rail moves on any edge.
module sr_latch_driver #(
  parameter int PULSE_W        = 3,
  parameter int GAP_W          = 2,
  parameter int CNT_W          = 4,
  parameter bit SKIP_REDUNDANT = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  sr_latch_driver_if.slave cmd,
  output logic             S,
  output logic             R,
  output logic             q_exp,
  output logic             q_valid,
  output logic             done,
  output logic             err
);

  typedef enum logic [2:0] {
    INIT_PULSE,
    INIT_GAP,
    IDLE,
    PULSE,
    GAP
  } state_t;

  localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] P_LAST = CNT_W'(PULSE_W - 1);
  localparam logic [CNT_W-1:0] P_INIT = CNT_W'(PULSE_W);
  localparam logic [CNT_W-1:0] G_LAST = CNT_W'(GAP_W - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             s_nxt, r_nxt;
  logic             q_nxt, qv_nxt;
  logic             done_nxt, err_nxt;

  logic fire;
  logic op_set, op_clr, op_bad;
  logic redundant, go_set, go_clr;

  assign cmd.cmd_ready = (state == IDLE);
  assign fire          = cmd.cmd_valid && cmd.cmd_ready;

  assign op_set    = (cmd.cmd_op == 2'b01);
  assign op_clr    = (cmd.cmd_op == 2'b10);
  assign op_bad    = !op_set && !op_clr;
  assign redundant = SKIP_REDUNDANT &&
                     ((op_set && q_exp) ||
                      (op_clr && !q_exp));
  assign go_set    = op_set && !redundant;
  assign go_clr    = op_clr && !redundant;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    s_nxt     = 1'b1;
    r_nxt     = 1'b1;
    q_nxt     = q_exp;
    qv_nxt    = q_valid;
    done_nxt  = 1'b0;
    err_nxt   = 1'b0;
    case (state)
      // cnt runs one past the pulse so R falls on the first edge out of reset
      INIT_PULSE: begin
        if (cnt == P_INIT) begin
          state_nxt = INIT_GAP;
          cnt_nxt   = '0;
        end else begin
          r_nxt   = 1'b0;
          cnt_nxt = cnt + ONE;
        end
      end
      INIT_GAP: begin
        if (cnt == G_LAST) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
          q_nxt     = 1'b0;
          qv_nxt    = 1'b1;
        end else begin
          cnt_nxt = cnt + ONE;
        end
      end
      IDLE: begin
        if (fire) begin
          unique case (1'b1)
            op_bad:    err_nxt  = 1'b1;
            redundant: done_nxt = 1'b1;
            go_set: begin
              state_nxt = PULSE;
              cnt_nxt   = '0;
              s_nxt     = 1'b0;
            end
            go_clr: begin
              state_nxt = PULSE;
              cnt_nxt   = '0;
              r_nxt     = 1'b0;
            end
          endcase
        end
      end
      // the low rail itself records which op is in flight
      PULSE: begin
        if (cnt == P_LAST) begin
          state_nxt = GAP;
          cnt_nxt   = '0;
          q_nxt     = !S;
        end else begin
          s_nxt   = S;
          r_nxt   = R;
          cnt_nxt = cnt + ONE;
        end
      end
      GAP: begin
        if (cnt == G_LAST) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
          done_nxt  = 1'b1;
        end else begin
          cnt_nxt = cnt + ONE;
        end
      end
      default: begin
        state_nxt = INIT_PULSE;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= INIT_PULSE;
      cnt     <= '0;
      S       <= 1'b1;
      R       <= 1'b1;
      q_exp   <= 1'b0;
      q_valid <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      S       <= s_nxt;
      R       <= r_nxt;
      q_exp   <= q_nxt;
      q_valid <= qv_nxt;
      done    <= done_nxt;
      err     <= err_nxt;
    end
  end

endmodule

// File: tb/tb_sr_latch_driver.sv
// Bench for sr_latch_driver: directed scenarios plus random traffic
// checked every cycle against a timeline model of expected outputs.
module tb_sr_latch_driver;

  localparam int PULSE_W = 3;
  localparam int GAP_W   = 2;
  localparam int CNT_W   = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic S, R, q_exp, q_valid, done, err;

  int checks = 0;
  int errors = 0;

  sr_latch_driver_if bus();

  sr_latch_driver #(
    .PULSE_W(PULSE_W),
    .GAP_W(GAP_W),
    .CNT_W(CNT_W),
    .SKIP_REDUNDANT(1'b1)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .cmd(bus),
    .S(S),
    .R(R),
    .q_exp(q_exp),
    .q_valid(q_valid),
    .done(done),
    .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, expv);
    end
  endtask

  // expected outputs for one clock cycle
  typedef struct packed {
    logic s, r, rdy, q, qv, dn, er;
  } cyc_t;

  cyc_t plan[$];
  cyc_t cur;
  logic m_live   = 1'b0;
  logic init_due = 1'b0;
  logic m_q      = 1'b0;
  logic m_qv     = 1'b0;

  function automatic cyc_t mk(logic s, logic r, logic rdy,
                              logic q, logic qv,
                              logic dn, logic er);
    cyc_t c;
    c.s = s; c.r = r; c.rdy = rdy;
    c.q = q; c.qv = qv; c.dn = dn; c.er = er;
    return c;
  endfunction

  // each accepted event appends the cycles it will produce
  always @(posedge clk) begin
    if (!rst_n) begin
      plan.delete();
      m_live   = 1'b1;
      init_due = 1'b1;
      m_q      = 1'b0;
      m_qv     = 1'b0;
      cur      = mk(1, 1, 0, 0, 0, 0, 0);
    end else if (m_live) begin
      if (init_due) begin
        init_due = 1'b0;
        for (int i = 0; i < PULSE_W; i++)
          plan.push_back(mk(1, 0, 0, 0, 0, 0, 0));
        for (int i = 0; i < GAP_W; i++)
          plan.push_back(mk(1, 1, 0, 0, 0, 0, 0));
        m_q  = 1'b0;
        m_qv = 1'b1;
      end else if (cur.rdy && bus.cmd_valid) begin
        logic want;
        want = (bus.cmd_op == 2'b01);
        if (bus.cmd_op == 2'b00 || bus.cmd_op == 2'b11) begin
          plan.push_back(mk(1, 1, 1, m_q, m_qv, 0, 1));
        end else if (want == m_q) begin
          plan.push_back(mk(1, 1, 1, m_q, m_qv, 1, 0));
        end else begin
          for (int i = 0; i < PULSE_W; i++)
            plan.push_back(mk(!want, want, 0, m_q, 1, 0, 0));
          m_q = want;
          for (int i = 0; i < GAP_W; i++)
            plan.push_back(mk(1, 1, 0, m_q, 1, 0, 0));
          plan.push_back(mk(1, 1, 1, m_q, 1, 1, 0));
        end
      end
      if (plan.size() > 0) cur = plan.pop_front();
      else cur = mk(1, 1, 1, m_q, m_qv, 0, 0);
    end
  end

  logic p_s, p_r, have_prev = 1'b0;

  always @(negedge clk) begin
    if (m_live) begin
      chk("S", S, cur.s);
      chk("R", R, cur.r);
      chk("cmd_ready", bus.cmd_ready, cur.rdy);
      chk("q_exp", q_exp, cur.q);
      chk("q_valid", q_valid, cur.qv);
      chk("done", done, cur.dn);
      chk("err", err, cur.er);
      chk("sr_not_00", !(S == 1'b0 && R == 1'b0), 1);
      if (have_prev)
        chk("sr_one_rail", !((S !== p_s) && (R !== p_r)), 1);
      p_s = S;
      p_r = R;
      have_prev = 1'b1;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic run_cmd(input logic [1:0] op);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    cyc();
    bus.cmd_valid = 1'b0;
    for (int k = 0; k < 20 && !bus.cmd_ready; k++) cyc();
    chk("run_cmd_ready", bus.cmd_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, k;
    rst_n = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_op = 2'b00;
    repeat (3) cyc();
    chk("rst_S", S, 1);
    chk("rst_R", R, 1);
    chk("rst_ready", bus.cmd_ready, 0);
    chk("rst_qv", q_valid, 0);

    // init clear sequence
    rst_n = 1'b1;
    cyc();
    chk("init_c1_R", R, 0);
    chk("init_c1_S", S, 1);
    cyc(); cyc();
    chk("init_c3_R", R, 0);
    cyc();
    chk("init_c4_R", R, 1);
    cyc();
    chk("init_c5_ready", bus.cmd_ready, 0);
    cyc();
    chk("init_c6_ready", bus.cmd_ready, 1);
    chk("init_c6_qv", q_valid, 1);
    chk("init_c6_q", q_exp, 0);

    // single set command
    bus.cmd_valid = 1'b1;
    bus.cmd_op = 2'b01;
    cyc();
    bus.cmd_valid = 1'b0;
    chk("set_t1_S", S, 0);
    chk("set_t1_R", R, 1);
    cyc(); cyc();
    chk("set_t3_S", S, 0);
    cyc();
    chk("set_t4_S", S, 1);
    chk("set_t4_q", q_exp, 1);
    cyc();
    chk("set_t5_done", done, 0);
    cyc();
    chk("set_t6_done", done, 1);
    chk("set_t6_ready", bus.cmd_ready, 1);

    // redundant set
    bus.cmd_valid = 1'b1;
    bus.cmd_op = 2'b01;
    cyc();
    bus.cmd_valid = 1'b0;
    chk("redund_done", done, 1);
    chk("redund_ready", bus.cmd_ready, 1);
    chk("redund_S", S, 1);
    cyc();
    chk("redund_done_off", done, 0);

    // illegal ops
    bus.cmd_valid = 1'b1;
    bus.cmd_op = 2'b11;
    cyc();
    bus.cmd_valid = 1'b0;
    chk("ill11_err", err, 1);
    chk("ill11_done", done, 0);
    chk("ill11_q", q_exp, 1);
    cyc();
    chk("ill_err_off", err, 0);
    bus.cmd_valid = 1'b1;
    bus.cmd_op = 2'b00;
    cyc();
    bus.cmd_valid = 1'b0;
    chk("ill00_err", err, 1);
    chk("ill00_R", R, 1);
    cyc();

    // back-to-back set then clear with valid held
    run_cmd(2'b10);
    bus.cmd_valid = 1'b1;
    bus.cmd_op = 2'b01;
    cyc();
    chk("b2b_s_low", S, 0);
    bus.cmd_op = 2'b10;
    k = 0;
    while (S !== 1'b1 && k < 10) begin cyc(); k++; end
    n = 1;
    k = 0;
    while (R !== 1'b0 && k < 10) begin
      cyc();
      if (R !== 1'b0) n++;
      k++;
    end
    bus.cmd_valid = 1'b0;
    chk("b2b_gap11", n, GAP_W + 1);
    chk("b2b_r_low", R, 0);
    k = 0;
    while (done !== 1'b1 && k < 10) begin cyc(); k++; end
    chk("b2b_done", done, 1);
    chk("b2b_q", q_exp, 0);

    // reset during the second cycle of an S pulse
    bus.cmd_valid = 1'b1;
    bus.cmd_op = 2'b01;
    cyc();
    bus.cmd_valid = 1'b0;
    cyc();
    chk("midrst_S_low", S, 0);
    rst_n = 1'b0;
    cyc();
    chk("midrst_S", S, 1);
    chk("midrst_R", R, 1);
    chk("midrst_qv", q_valid, 0);
    rst_n = 1'b1;
    cyc();
    chk("reinit_R", R, 0);
    repeat (PULSE_W + GAP_W) cyc();
    chk("reinit_ready", bus.cmd_ready, 1);
    chk("reinit_qv", q_valid, 1);
    chk("reinit_q", q_exp, 0);

    // random traffic
    for (int i = 0; i < 800; i++) begin
      rst_n = ($urandom_range(0, 199) != 0);
      bus.cmd_valid = ($urandom_range(0, 2) != 0);
      bus.cmd_op = 2'($urandom_range(0, 3));
      cyc();
    end
    rst_n = 1'b1;
    bus.cmd_valid = 1'b0;
    repeat (12) cyc();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
